uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_fifo.sv | 57 +++++
 rtl/uart.sv | 236 +++++++++++++++++++++++
 tb/tb_uart.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX/RX state encodings and line levels.
package uart_pkg;

    localparam int DATA_BITS = 8;

    // Line levels that frame a character on the wire.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count. Push and pop in the same cycle both
// take effect; a push on a full FIFO only succeeds when a pop frees a slot.
// dout reads as zero while the FIFO is empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // Storage write.
    // NOTE: the array has no reset; count_q alone says which entries are valid,
    // and an unreset array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is 2^n.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + (PTR_W+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/uart.sv
// 8N1 UART with TX and RX FIFOs.
// Optional: define UART_RX_SYNC_EN to pass uart_rx through a 2-flop
// synchronizer (adds 2 cycles of RX latency); otherwise uart_rx is used as-is.
module uart
    import uart_pkg::*;
#(
    parameter int BAUDRATE_COUNT = 5,
    parameter int FIFO_SIZE      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       rx_ready,
    input  logic       rx,
    output logic [7:0] rx_data,
    input  logic       tx,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       uart_tx
);

    localparam int                CNT_W     = $clog2(BAUDRATE_COUNT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BAUDRATE_COUNT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(BAUDRATE_COUNT / 2 - 1);
    localparam int                BIT_W     = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // ---------------- FIFOs ----------------
    logic                 tx_fifo_pop;
    logic                 tx_fifo_empty;
    logic [DATA_BITS-1:0] tx_fifo_dout;
    logic                 rx_fifo_full;
    logic                 rx_fifo_empty;
    logic                 rx_push_q, rx_push_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_SIZE)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (tx),
        .pop   (tx_fifo_pop),
        .din   (tx_data),
        .dout  (tx_fifo_dout),
        .full  (tx_full),
        .empty (tx_fifo_empty)
    );

    // A received byte is dropped when the RX FIFO is full, unless a pop frees a slot.
    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_SIZE)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (rx_push_q & (~rx_fifo_full | rx)),
        .pop   (rx),
        .din   (rx_shift_q),
        .dout  (rx_data),
        .full  (rx_fifo_full),
        .empty (rx_fifo_empty)
    );

    assign rx_ready = ~rx_fifo_empty;

    // ---------------- RX input conditioning ----------------
    logic rx_in;
`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync_q;

    // Two-stage synchronizer, idling high like the line itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_sync_q <= 2'b11;
        else      rx_sync_q <= {rx_sync_q[0], uart_rx};
    end
    assign rx_in = rx_sync_q[1];
`else
    assign rx_in = uart_rx;
`endif

    // ---------------- Transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 uart_tx_q, uart_tx_d;

    assign uart_tx = uart_tx_q;

    // TX next state: walk start/data/stop bit times, chaining frames while data waits.
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_fifo_pop = 1'b0;
        uart_tx_d   = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_fifo_empty) begin
                    tx_fifo_pop = 1'b1;
                    tx_shift_d  = tx_fifo_dout;
                    tx_cnt_d    = '0;
                    tx_state_d  = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BIT_LAST) tx_state_d = TX_STOP;
                    else                      tx_bit_d   = tx_bit_q + BIT_W'(1);
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (!tx_fifo_empty) begin
                        tx_fifo_pop = 1'b1;
                        tx_shift_d  = tx_fifo_dout;
                        tx_state_d  = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
        endcase
        // Line level follows the state being entered so uart_tx is a clean register.
        case (tx_state_d)
            TX_IDLE:  uart_tx_d = 1'b1;
            TX_START: uart_tx_d = START_BIT;
            TX_DATA:  uart_tx_d = tx_shift_d[0];
            TX_STOP:  uart_tx_d = STOP_BIT;
        endcase
    end

    // TX state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            uart_tx_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            uart_tx_q  <= uart_tx_d;
        end
    end

    // ---------------- Receiver ----------------
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0] rx_bit_q, rx_bit_d;
    logic             rx_prev_q;

    // RX next state: falling edge starts a frame, mid-start check, then sample every bit time.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                // Requiring the previous sample high also waits out a stuck-low line.
                if (rx_prev_q && rx_in == START_BIT) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = (rx_in == START_BIT) ? RX_DATA : RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
                    else                      rx_bit_d   = rx_bit_q + BIT_W'(1);
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_push_d  = (rx_in == STOP_BIT);
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // RX state registers; rx_push_q writes the byte one cycle after the stop sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_push_q  <= 1'b0;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_push_q  <= rx_push_d;
            rx_prev_q  <= rx_in;
        end
    end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart (BAUDRATE_COUNT=5, FIFO_SIZE=4).
// The model holds the bytes that must appear on uart_tx and in the RX FIFO;
// one compare process checks uart_tx and rx_ready/rx_data every cycle.
module tb_uart;

    localparam int BAUD = 5;
`ifdef UART_RX_SYNC_EN
    localparam int RX_LAT = 2;
`else
    localparam int RX_LAT = 0;
`endif

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic       rx_ready;
    logic       rx;
    logic [7:0] rx_data;
    logic       tx;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       uart_tx;

    uart #(.BAUDRATE_COUNT(BAUD), .FIFO_SIZE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rx_ready (rx_ready),
        .rx       (rx),
        .rx_data  (rx_data),
        .tx       (tx),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .uart_tx  (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0] tx_exp[$];     // bytes that must still appear on uart_tx, in order
    logic [7:0] rx_exp[$];     // expected RX FIFO contents, head first
    int         tx_starts[$];  // cycle number of every observed start bit
    int         frames_done = 0;
    logic [9:0] last_frame;    // mid-bit samples of the last finished frame
    int         cyc = 0;
    bit         in_frame = 0;
    int         fidx;
    logic [7:0] fbyte;
    logic [9:0] fbits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Level of the wire during bit slot 0..9 of an 8N1 frame.
    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            in_frame = 0;
            check("reset uart_tx", 32'(uart_tx), 32'd1);
            check("reset tx_full", 32'(tx_full), 32'd0);
            check("reset rx_ready", 32'(rx_ready), 32'd0);
            check("reset rx_data", 32'(rx_data), 32'd0);
        end else begin
            check("rx_ready", 32'(rx_ready), 32'(rx_exp.size() != 0));
            if (rx_exp.size() != 0) check("rx_data", 32'(rx_data), 32'(rx_exp[0]));
            if (!in_frame && uart_tx == 1'b0) begin
                if (tx_exp.size() == 0) begin
                    check("unexpected tx start", 32'(uart_tx), 32'd1);
                end else begin
                    fbyte = tx_exp.pop_front();
                    in_frame = 1;
                    fidx = 0;
                    tx_starts.push_back(cyc);
                end
            end
            if (in_frame) begin
                check("uart_tx bit", 32'(uart_tx), 32'(frame_bit(fbyte, fidx / BAUD)));
                if (fidx % BAUD == BAUD / 2) fbits[fidx / BAUD] = uart_tx;
                fidx++;
                if (fidx == 10 * BAUD) begin
                    in_frame = 0;
                    frames_done++;
                    last_frame = fbits;
                end
            end
        end
    end

    task automatic push_tx(input logic [7:0] b, input bit accepted);
        @(posedge clk); #1;
        tx = 1'b1;
        tx_data = b;
        if (accepted) tx_exp.push_back(b);
        @(posedge clk); #1;
        tx = 1'b0;
    endtask

    task automatic pop_rx();
        @(posedge clk); #1;
        rx = 1'b1;
        @(posedge clk); #1;
        rx = 1'b0;
        if (rx_exp.size() != 0) void'(rx_exp.pop_front());
    endtask

    // Drive one frame; a valid byte lands in the FIFO 49 edges after the first drive edge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            if (i == 9) begin
                repeat (4 + RX_LAT) @(posedge clk);
                #1;
                if (stop && rx_exp.size() < 4) rx_exp.push_back(b);
                @(posedge clk); #1;
            end else begin
                repeat (BAUD) @(posedge clk);
                #1;
            end
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_frames(input string name, input int n, input int budget);
        for (int i = 0; i < budget && frames_done < n; i++) @(posedge clk);
        #1;
        check(name, 32'(frames_done), 32'(n));
    endtask

    int base;

    initial begin
        rst = 1'b0; uart_rx = 1'b1; rx = 1'b0; tx = 1'b0; tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset uart_tx lit", 32'(uart_tx), 32'd1);
        check("reset tx_full lit", 32'(tx_full), 32'd0);
        check("reset rx_ready lit", 32'(rx_ready), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single byte 0xA5
        push_tx(8'hA5, 1);
        wait_frames("a5 frame done", 1, 120);
        check("a5 frame bits", 32'(last_frame), 32'(10'b1101001010));
        repeat (10) @(posedge clk);

        // Burst of seven pushes, two dropped while full
        base = tx_starts.size();
        push_tx(8'hA5, 1); #1 check("full after 1", 32'(tx_full), 32'd0);
        push_tx(8'h5A, 1); #1 check("full after 2", 32'(tx_full), 32'd0);
        push_tx(8'h3C, 1); #1 check("full after 3", 32'(tx_full), 32'd0);
        push_tx(8'hC3, 1); #1 check("full after 4", 32'(tx_full), 32'd0);
        push_tx(8'h69, 1); #1 check("full after 5", 32'(tx_full), 32'd1);
        push_tx(8'h96, 0); #1 check("full after 6", 32'(tx_full), 32'd1);
        push_tx(8'hA5, 0); #1 check("full after 7", 32'(tx_full), 32'd1);
        wait_frames("burst frames done", 6, 400);
        for (int k = base + 1; k < base + 5 && k < tx_starts.size(); k++)
            check("back-to-back gap", 32'(tx_starts[k] - tx_starts[k-1]), 32'd50);
        check("burst last byte", 32'(last_frame), 32'({1'b1, 8'h69, 1'b0}));
        repeat (60) @(posedge clk);
        #1;
        check("burst frame count", 32'(frames_done), 32'd6);
        check("tx_full after burst", 32'(tx_full), 32'd0);

        // Valid RX frame, then pop
        send_frame(8'h3C, 1'b1);
        @(negedge clk);
        check("rx 3c ready", 32'(rx_ready), 32'd1);
        check("rx 3c data", 32'(rx_data), 32'h3C);
        pop_rx();
        @(negedge clk);
        check("rx ready after pop", 32'(rx_ready), 32'd0);

        // Framing error followed by a good frame
        send_frame(8'h69, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("framing err dropped", 32'(rx_ready), 32'd0);
        send_frame(8'h96, 1'b1);
        @(negedge clk);
        check("rx 96 data", 32'(rx_data), 32'h96);
        pop_rx();

        // Start-bit glitch aborted at the mid-bit check
        @(posedge clk); #1 uart_rx = 1'b0;
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("glitch ignored", 32'(rx_ready), 32'd0);

        // RX FIFO overflow: fifth byte dropped; extra pop on empty ignored
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        send_frame(8'h55, 1'b1);
        @(negedge clk);
        check("rx head after overflow", 32'(rx_data), 32'h11);
        repeat (3) pop_rx();
        @(negedge clk);
        check("rx last kept", 32'(rx_data), 32'h44);
        pop_rx();
        pop_rx();
        @(negedge clk);
        check("rx empty after pops", 32'(rx_ready), 32'd0);

        // Reset in the middle of a TX burst
        base = frames_done;
        push_tx(8'h81, 1);
        push_tx(8'h42, 1);
        push_tx(8'h24, 1);
        push_tx(8'h18, 1);
        push_tx(8'hE7, 1);
        #1 check("full before reset", 32'(tx_full), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        #1;
        check("mid-frame reset uart_tx", 32'(uart_tx), 32'd1);
        check("mid-frame reset tx_full", 32'(tx_full), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        check("nothing sent after reset", 32'(frames_done), 32'(base));
        push_tx(8'h5A, 1);
        wait_frames("post-reset frame", base + 1, 120);
        check("post-reset byte", 32'(last_frame), 32'({1'b1, 8'h5A, 1'b0}));
        repeat (5) @(posedge clk);
        check("tx queue drained", 32'(tx_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
